// File: rtl/spi_pkg.sv
// Shared constants, command codes and FSM encoding for the SPI SRAM master controller.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 11;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [1:0] {
    CmdWrAddr = 2'b00,
    CmdWrData = 2'b01,
    CmdRdAddr = 2'b10,
    CmdRdData = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StTurn,
    StCapture,
    StGap
  } spi_state_e;

  function automatic logic [FRAME_BITS-1:0] build_frame(spi_cmd_e cmd,
                                                        logic [DATA_BITS-1:0] payload);
    return {cmd[1], cmd, payload};
  endfunction

  // Read-data frames carry no payload; it is driven as zero.
  function automatic logic [DATA_BITS-1:0] data_payload(logic op, logic [DATA_BITS-1:0] wdata);
    return op ? '0 : wdata;
  endfunction

endpackage

// File: rtl/spi_frame_shifter.sv
// MOSI frame serializer and MISO deserializer sharing one 4-bit bit counter.
module spi_frame_shifter
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  shift_en,
  input  logic                  capture_en,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  last_bit,
  output logic [DATA_BITS-1:0]  capture_data
);

  logic [FRAME_BITS-1:0] tx_q;
  logic [DATA_BITS-1:0]  rx_q;
  logic [3:0]            bit_cnt_q;
  logic [3:0]            last_idx;

  assign last_idx     = capture_en ? 4'(DATA_BITS - 1) : 4'(FRAME_BITS - 1);
  assign last_bit     = (shift_en || capture_en) && (bit_cnt_q == last_idx);
  assign mosi         = tx_q[FRAME_BITS-1];
  // Includes the bit being sampled this edge so the final byte is usable immediately.
  assign capture_data = {rx_q[DATA_BITS-2:0], miso};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
    end else if (load) begin
      tx_q      <= frame;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      tx_q      <= {tx_q[FRAME_BITS-2:0], 1'b0};
      bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 4'd1;
    end else if (capture_en) begin
      rx_q      <= capture_data;
      bit_cnt_q <= last_bit ? '0 : bit_cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI SRAM master: turns host read/write requests into address + data frames.
// Optional SPI_MASTER_ADDR_SKIP_EN omits a repeated address frame for the same op.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned TURNAROUND = 2,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_op,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       ss_n,
  output logic       MOSI,
  input  logic       MISO
);

  // TURNAROUND and GAP_CYCLES are limited to 256; a zero GAP_CYCLES still yields one gap cycle.
  localparam int unsigned WaitW    = 8;
  localparam int unsigned TurnLast = (TURNAROUND > 0) ? TURNAROUND - 1 : 0;
  localparam int unsigned GapLast  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  spi_state_e           state_q, state_d;
  logic [WaitW-1:0]     wait_cnt_q, wait_cnt_d;
  logic                 data_phase_q, data_phase_d;
  logic                 op_q;
  logic [7:0]           addr_q, wdata_q;
  logic                 ready_en_q, rsp_valid_q;
  logic [7:0]           rsp_rdata_q;
  logic                 accept, load, shift_en, capture_en, rsp_set, rdata_set, skip;
  logic                 sh_mosi, last_bit;
  logic [DATA_BITS-1:0] capture_data;
  spi_cmd_e             load_cmd;
  logic [7:0]           load_payload;

  assign req_ready = ready_en_q && (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ss_n      = !(state_q inside {StShift, StTurn, StCapture});
  assign MOSI      = (state_q == StShift) && sh_mosi;

`ifdef SPI_MASTER_ADDR_SKIP_EN
  logic       last_wr_vld_q, last_rd_vld_q;
  logic [7:0] last_wr_addr_q, last_rd_addr_q;

  assign skip = req_op ? (last_rd_vld_q && (last_rd_addr_q == req_addr))
                       : (last_wr_vld_q && (last_wr_addr_q == req_addr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_wr_vld_q  <= 1'b0;
      last_rd_vld_q  <= 1'b0;
      last_wr_addr_q <= '0;
      last_rd_addr_q <= '0;
    end else if (accept) begin
      if (req_op) begin
        last_rd_vld_q  <= 1'b1;
        last_rd_addr_q <= req_addr;
      end else begin
        last_wr_vld_q  <= 1'b1;
        last_wr_addr_q <= req_addr;
      end
    end
  end
`else
  assign skip = 1'b0;
`endif

  // The first frame is built from the live request because the field latches update this edge.
  assign load_cmd     = accept ? spi_cmd_e'({req_op, skip}) : spi_cmd_e'({op_q, 1'b1});
  assign load_payload = accept ? (skip ? data_payload(req_op, req_wdata) : req_addr)
                               : data_payload(op_q, wdata_q);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    data_phase_d = data_phase_q;
    accept       = 1'b0;
    load         = 1'b0;
    shift_en     = 1'b0;
    capture_en   = 1'b0;
    rsp_set      = 1'b0;
    rdata_set    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          accept       = 1'b1;
          load         = 1'b1;
          data_phase_d = skip;
          state_d      = StShift;
        end
      end
      StShift: begin
        shift_en = 1'b1;
        if (last_bit) begin
          if ({op_q, data_phase_q} == CmdRdData) begin
            state_d = (TURNAROUND == 0) ? StCapture : StTurn;
          end else begin
            state_d = StGap;
            rsp_set = data_phase_q;
          end
        end
      end
      StTurn: begin
        if (wait_cnt_q == WaitW'(TurnLast)) begin
          wait_cnt_d = '0;
          state_d    = StCapture;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StCapture: begin
        capture_en = 1'b1;
        if (last_bit) begin
          state_d   = StGap;
          rsp_set   = 1'b1;
          rdata_set = 1'b1;
        end
      end
      StGap: begin
        if (wait_cnt_q == WaitW'(GapLast)) begin
          wait_cnt_d = '0;
          if (data_phase_q) begin
            state_d = StIdle;
          end else begin
            state_d      = StShift;
            load         = 1'b1;
            data_phase_d = 1'b1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      wait_cnt_q   <= '0;
      data_phase_q <= 1'b0;
      op_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ready_en_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      data_phase_q <= data_phase_d;
      ready_en_q   <= 1'b1;
      rsp_valid_q  <= rsp_set;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (rdata_set) rsp_rdata_q <= capture_data;
    end
  end

  spi_frame_shifter u_shifter (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (load),
    .frame        (build_frame(load_cmd, load_payload)),
    .shift_en     (shift_en),
    .capture_en   (capture_en),
    .miso         (MISO),
    .mosi         (sh_mosi),
    .last_bit     (last_bit),
    .capture_data (capture_data)
  );

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: SPI slave + SRAM model on the wire, request-level reference model.
module tb_spi_master_ctrl;

  localparam int unsigned T = 2;
  localparam int unsigned G = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_op;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       ss_n, MOSI, MISO;

  always #5 clk = ~clk;

  spi_master_ctrl #(.TURNAROUND(T), .GAP_CYCLES(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .ss_n      (ss_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- slave + SRAM model and wire monitor ----------------
  logic [7:0]  sram [256];
  logic [10:0] obs_q [$];
  logic [10:0] sh;
  logic [7:0]  slv_wr_addr, slv_rd_addr, rd_byte;
  int          nbits = 0, low_run = 0, hi_run = 0, tail = 0;
  logic        had_frame = 1'b0, tail_on = 1'b0, rsp_prev = 1'b0;
  int          idle_bad = 0, rsp_pulses = 0, rsp_wide = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0; low_run = 0; hi_run = 0; had_frame = 1'b0; tail_on = 1'b0;
      rsp_prev = 1'b0;
      obs_q.delete();
      MISO = 1'($urandom);
    end else begin
      if (rsp_valid && !rsp_prev) rsp_pulses++;
      if (rsp_valid && rsp_prev) rsp_wide++;
      rsp_prev = rsp_valid;
      if (tail_on) tail++;
      if (ss_n) begin
        if (MOSI !== 1'b0) idle_bad++;
        if (low_run > 0) begin
          check_eq("ss_low_len", low_run, (sh[9:8] == 2'b11) ? 19 + T : 11);
          had_frame = 1'b1;
        end
        low_run = 0; nbits = 0; hi_run++; tail_on = 1'b0;
      end else begin
        if (low_run == 0 && had_frame) check_eq("ss_gap_min", 32'(hi_run >= G), 1);
        low_run++; hi_run = 0;
        if (nbits < 11) begin
          sh = {sh[9:0], MOSI};
          nbits++;
          if (nbits == 11) begin
            obs_q.push_back(sh);
            case (sh[9:8])
              2'b00: slv_wr_addr = sh[7:0];
              2'b01: sram[slv_wr_addr] = sh[7:0];
              2'b10: slv_rd_addr = sh[7:0];
              default: begin tail_on = 1'b1; tail = 0; end
            endcase
          end
        end
      end
      // Slave answers a read-data frame only after the turnaround; junk elsewhere.
      if (tail_on && tail >= T + 1 && tail <= T + 8) begin
        rd_byte = sram[slv_rd_addr];
        MISO = rd_byte[7 - (tail - T - 1)];
      end else begin
        MISO = 1'($urandom);
      end
    end
  end

  // ---------------- request-level reference model ----------------
  logic [7:0]  ref_mem [256];
  logic [10:0] exp_q [$];
  logic [7:0]  last_rd = 8'h00;
  int          done_cnt = 0;
  logic        m_wr_vld = 1'b0, m_rd_vld = 1'b0;
  logic [7:0]  m_wr_addr = 8'h00, m_rd_addr = 8'h00;

  task automatic model_reset();
    m_wr_vld = 1'b0; m_rd_vld = 1'b0; last_rd = 8'h00;
    exp_q.delete();
  endtask

  // Must be called at a negedge; returns at the negedge where rsp_valid is seen.
  task automatic do_req(input logic op, input logic [7:0] addr, input logic [7:0] wdata,
                        input logic hold, input logic scramble, output int nframes);
    int   lat, exp_lat, w;
    logic skip, bad_ready;
    skip = 1'b0;
`ifdef SPI_MASTER_ADDR_SKIP_EN
    if (op) begin
      skip = m_rd_vld && (m_rd_addr == addr); m_rd_vld = 1'b1; m_rd_addr = addr;
    end else begin
      skip = m_wr_vld && (m_wr_addr == addr); m_wr_vld = 1'b1; m_wr_addr = addr;
    end
`endif
    if (!skip) exp_q.push_back({op, op, 1'b0, addr});
    exp_q.push_back({op, op, 1'b1, op ? 8'h00 : wdata});
    exp_lat = (op ? 30 + int'(T) : 22) + int'(G) - (skip ? 11 + int'(G) : 0);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    w = 0;
    while (req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    if (req_ready !== 1'b1) begin
      check_eq("accept_timeout", 0, 1);
      req_valid = 1'b0; nframes = 0; exp_q.delete(); obs_q.delete();
      return;
    end
    @(negedge clk);
    lat = 0;
    if (!hold) req_valid = 1'b0;
    if (scramble) begin
      req_op = ~op; req_addr = ~addr; req_wdata = 8'($urandom);
    end
    if (!op) ref_mem[addr] = wdata;
    bad_ready = 1'b0;
    while (rsp_valid !== 1'b1 && lat < 200) begin
      if (req_ready !== 1'b0) bad_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    check_eq("latency", lat, exp_lat);
    check_eq("ready_low_busy", bad_ready, 0);
    if (op) begin
      last_rd = ref_mem[addr];
      check_eq("rsp_rdata", rsp_rdata, last_rd);
    end else begin
      check_eq("rdata_hold", rsp_rdata, last_rd);
    end
    nframes = obs_q.size();
    check_eq("frame_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) check_eq("frame", obs_q[i], exp_q[i]);
    obs_q.delete(); exp_q.delete();
    done_cnt++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   nf, pulses0, w;
    logic hold;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      sram[i] = v; ref_mem[i] = v;
    end
    req_valid = 1'b0; req_op = 1'b0; req_addr = '0; req_wdata = '0; MISO = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("rst_ss_n", ss_n, 1);
    check_eq("rst_mosi", MOSI, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rdata", rsp_rdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("ready_before_edge", req_ready, 0);
    @(negedge clk);
    check_eq("ready_after_edge", req_ready, 1);

    do_req(1'b0, 8'h3C, 8'hA5, 1'b0, 1'b0, nf);
    do_req(1'b0, 8'h10, 8'h5A, 1'b0, 1'b0, nf);
    do_req(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, nf);
    check_eq("read_back_5a", rsp_rdata, 8'h5A);

    // Abort a read of 0x10 during bit 6 of its address frame.
    req_valid = 1'b1; req_op = 1'b1; req_addr = 8'h10; req_wdata = 8'h00;
    w = 0;
    while (req_ready !== 1'b1 && w < 100) begin @(negedge clk); w++; end
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("abort_mid_frame", ss_n, 0);
    pulses0 = rsp_pulses;
    rst_n = 1'b0;
    #1;
    check_eq("abort_ss_n", ss_n, 1);
    check_eq("abort_mosi", MOSI, 0);
    check_eq("abort_ready", req_ready, 0);
    check_eq("abort_rsp_valid", rsp_valid, 0);
    check_eq("abort_rdata", rsp_rdata, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_ready_rise", req_ready, 1);
    repeat (40) @(negedge clk);
    check_eq("abort_no_rsp", rsp_pulses, pulses0);
    do_req(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, nf);

    // Fields changed right after acceptance must not leak into the frames.
    do_req(1'b0, 8'h77, 8'h11, 1'b0, 1'b1, nf);
    do_req(1'b1, 8'h77, 8'h00, 1'b0, 1'b1, nf);

    // Back-to-back with req_valid held high throughout.
    for (int i = 0; i < 6; i++)
      do_req(1'(i % 2), 8'h30 + 8'(i / 2), 8'($urandom), 1'(i != 5), 1'b0, nf);

`ifdef SPI_MASTER_ADDR_SKIP_EN
    do_req(1'b1, 8'h20, 8'h00, 1'b0, 1'b0, nf);
    do_req(1'b1, 8'h20, 8'h00, 1'b0, 1'b0, nf);
    check_eq("skip_second_read", nf, 1);
    do_req(1'b1, 8'h21, 8'h00, 1'b0, 1'b0, nf);
    check_eq("new_addr_both", nf, 2);
`endif

    for (int i = 0; i < 40; i++) begin
      hold = (i == 39) ? 1'b0 : 1'($urandom);
      do_req(1'($urandom), 8'h40 + 8'($urandom_range(0, 5)), 8'($urandom), hold,
             1'($urandom), nf);
    end
    req_valid = 1'b0;
    repeat (10) @(negedge clk);

    check_eq("mosi_idle_zero", idle_bad, 0);
    check_eq("rsp_one_cycle", rsp_wide, 0);
    check_eq("rsp_count", rsp_pulses, done_cnt);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
